// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Multiply hold FSM encoding.
  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  localparam int REG_BITS = 5;
  localparam int PC_INC   = 4;

  // Increment val by one, sticking at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] top_val;
    top_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= top_val) ? top_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/mul_hold_fsm.sv
// Holds the pipeline while a multi-cycle multiply occupies EX.
// A multiply is held for MUL_LAT-1 cycles: its first EX cycle (IDLE) plus
// MUL_LAT-2 BUSY cycles. DONE then waits for the memory side to release so
// the same instruction is not counted twice.
module mul_hold_fsm
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic EX_mul,
  input  logic mem_busy,
  output logic mul_hold,
  output logic mul_busy
);

  localparam bit         MUL_MULTI = (MUL_LAT > 1);
  localparam logic [2:0] CNT_INIT  = 3'(MUL_LAT - 2);

  mul_state_t state;
  logic [2:0] cnt;
  logic       busy_q;

  // State, down-counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (EX_mul && MUL_MULTI) begin
            busy_q <= 1'b1;
            if (MUL_LAT == 2) begin
              state <= MUL_DONE;
            end else begin
              state <= MUL_BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        MUL_BUSY: begin
          if (cnt <= 3'd1) begin
            state <= MUL_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        MUL_DONE: begin
          if (!mem_busy) begin
            state  <= MUL_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= MUL_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign mul_hold = !rst && ((state == MUL_BUSY) ||
                             ((state == MUL_IDLE) && EX_mul && MUL_MULTI));
  assign mul_busy = busy_q && !rst;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: global hold, load-use bubble, mispredict flush and
// the associated saturating performance counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int VPC_BITS = 32,
  parameter int MUL_LAT  = 4,
  parameter int PERF_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                D_valid,
  input  logic [REG_BITS-1:0] D_rs1,
  input  logic                D_rs1_used,
  input  logic [REG_BITS-1:0] D_rs2,
  input  logic                D_rs2_used,
  input  logic [REG_BITS-1:0] EX_rd,
  input  logic                EX_ld,
  input  logic                EX_mul,
  input  logic                EX_brn,
  input  logic                EX_BP_taken,
  input  logic [VPC_BITS-1:0] EX_BP_target_pc,
  input  logic                EX_br_taken,
  input  logic [VPC_BITS-1:0] EX_br_target,
  input  logic [VPC_BITS-1:0] EX_pc,
  input  logic                mem_busy,
  output logic                pipe_hold,
  output logic                stall_D,
  output logic                stall_F,
  output logic                EX_taken,
  output logic [VPC_BITS-1:0] redirect_pc,
  output logic                mul_busy,
  output logic [PERF_W-1:0]   perf_stall,
  output logic [PERF_W-1:0]   perf_flush,
  output logic [PERF_W-1:0]   perf_hold
);

  logic mul_hold;
  logic mispredict;
  logic hazard;

  mul_hold_fsm #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .EX_mul   (EX_mul),
    .mem_busy (mem_busy),
    .mul_hold (mul_hold),
    .mul_busy (mul_busy)
  );

  // Hold beats flush beats bubble; everything is quiet during reset.
  always_comb begin
    mispredict = EX_brn && ((EX_br_taken != EX_BP_taken) ||
                            (EX_br_taken && (EX_BP_target_pc != EX_br_target)));
    hazard = D_valid && EX_ld && (EX_rd != '0) &&
             ((D_rs1_used && (D_rs1 == EX_rd)) || (D_rs2_used && (D_rs2 == EX_rd)));
    pipe_hold   = !rst && (mem_busy || mul_hold);
    EX_taken    = !rst && mispredict && !pipe_hold;
    stall_D     = !rst && hazard && !pipe_hold && !EX_taken;
    stall_F     = stall_D;
    redirect_pc = '0;
    if (!rst) begin
      redirect_pc = EX_br_taken ? EX_br_target : EX_pc + VPC_BITS'(PC_INC);
    end
  end

  // Event counters, each sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall <= '0;
      perf_flush <= '0;
      perf_hold  <= '0;
    end else begin
      if (stall_D) perf_stall <= PERF_W'(sat_inc(64'(perf_stall), PERF_W));
      if (EX_taken) perf_flush <= PERF_W'(sat_inc(64'(perf_flush), PERF_W));
      if (pipe_hold) perf_hold <= PERF_W'(sat_inc(64'(perf_hold), PERF_W));
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// scored against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int VPC  = 32;
  localparam int LAT  = 4;
  localparam int PW   = 8;
  localparam int PMAX = (1 << PW) - 1;

  typedef struct packed {
    logic        rst;
    logic        d_valid;
    logic [4:0]  rs1;
    logic        rs1_used;
    logic [4:0]  rs2;
    logic        rs2_used;
    logic [4:0]  ex_rd;
    logic        ld;
    logic        mul;
    logic        brn;
    logic        bp_taken;
    logic [31:0] bp_tgt;
    logic        br_taken;
    logic [31:0] br_tgt;
    logic [31:0] pc;
    logic        mem_busy;
  } stim_t;

  typedef struct packed {
    logic        hold;
    logic        stall_d;
    logic        stall_f;
    logic        taken;
    logic [31:0] rpc;
    logic        busy;
    logic [7:0]  ps;
    logic [7:0]  pf;
    logic [7:0]  ph;
  } exp_t;

  localparam int EXP_W = $bits(exp_t);

  logic clk;
  logic rst;
  logic D_valid, D_rs1_used, D_rs2_used;
  logic [4:0] D_rs1, D_rs2, EX_rd;
  logic EX_ld, EX_mul, EX_brn, EX_BP_taken, EX_br_taken, mem_busy;
  logic [VPC-1:0] EX_BP_target_pc, EX_br_target, EX_pc;
  logic pipe_hold, stall_D, stall_F, EX_taken, mul_busy;
  logic [VPC-1:0] redirect_pc;
  logic [PW-1:0] perf_stall, perf_flush, perf_hold;

  logic [EXP_W-1:0] exp_q[$];
  int checks;
  int failures;

  // Reference model state: hold cycles left for the multiply in EX, and
  // whether a finished multiply is still waiting to leave EX.
  int m_hold_left;
  bit m_done_wait;
  int m_ps, m_pf, m_ph;

  pipe_hazard_ctrl #(.VPC_BITS(VPC), .MUL_LAT(LAT), .PERF_W(PW)) dut (
    .clk             (clk),
    .rst             (rst),
    .D_valid         (D_valid),
    .D_rs1           (D_rs1),
    .D_rs1_used      (D_rs1_used),
    .D_rs2           (D_rs2),
    .D_rs2_used      (D_rs2_used),
    .EX_rd           (EX_rd),
    .EX_ld           (EX_ld),
    .EX_mul          (EX_mul),
    .EX_brn          (EX_brn),
    .EX_BP_taken     (EX_BP_taken),
    .EX_BP_target_pc (EX_BP_target_pc),
    .EX_br_taken     (EX_br_taken),
    .EX_br_target    (EX_br_target),
    .EX_pc           (EX_pc),
    .mem_busy        (mem_busy),
    .pipe_hold       (pipe_hold),
    .stall_D         (stall_D),
    .stall_F         (stall_F),
    .EX_taken        (EX_taken),
    .redirect_pc     (redirect_pc),
    .mul_busy        (mul_busy),
    .perf_stall      (perf_stall),
    .perf_flush      (perf_flush),
    .perf_hold       (perf_hold)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= PMAX) ? PMAX : v + 1;
  endfunction

  // Reference model: expected outputs for one cycle, then advance past the edge.
  task automatic model(input stim_t s);
    exp_t e;
    bit busy, mh, hold, misp, haz, tk, sd;
    busy = (m_hold_left > 0) || m_done_wait;
    if (!s.rst && !busy && s.mul && LAT > 1) m_hold_left = LAT - 1;
    mh   = !s.rst && (m_hold_left > 0);
    hold = !s.rst && (s.mem_busy || mh);
    misp = s.brn && ((s.br_taken != s.bp_taken) || (s.br_taken && (s.bp_tgt != s.br_tgt)));
    tk   = !s.rst && misp && !hold;
    haz  = s.d_valid && s.ld && (s.ex_rd != 0) &&
           ((s.rs1_used && s.rs1 == s.ex_rd) || (s.rs2_used && s.rs2 == s.ex_rd));
    sd   = !s.rst && haz && !hold && !tk;
    e.hold    = hold;
    e.stall_d = sd;
    e.stall_f = sd;
    e.taken   = tk;
    e.rpc     = s.rst ? 32'd0 : (s.br_taken ? s.br_tgt : s.pc + 32'd4);
    e.busy    = !s.rst && busy;
    e.ps      = 8'(m_ps);
    e.pf      = 8'(m_pf);
    e.ph      = 8'(m_ph);
    exp_q.push_back(e);
    if (s.rst) begin
      m_hold_left = 0;
      m_done_wait = 1'b0;
      m_ps = 0;
      m_pf = 0;
      m_ph = 0;
    end else begin
      if (sd) m_ps = sat(m_ps);
      if (tk) m_pf = sat(m_pf);
      if (hold) m_ph = sat(m_ph);
      if (m_hold_left > 0) begin
        m_hold_left--;
        if (m_hold_left == 0) m_done_wait = 1'b1;
      end else if (m_done_wait && !s.mem_busy) begin
        m_done_wait = 1'b0;
      end
    end
  endtask

  // Driver: apply one cycle of inputs just after the active edge.
  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    rst             = s.rst;
    D_valid         = s.d_valid;
    D_rs1           = s.rs1;
    D_rs1_used      = s.rs1_used;
    D_rs2           = s.rs2;
    D_rs2_used      = s.rs2_used;
    EX_rd           = s.ex_rd;
    EX_ld           = s.ld;
    EX_mul          = s.mul;
    EX_brn          = s.brn;
    EX_BP_taken     = s.bp_taken;
    EX_BP_target_pc = s.bp_tgt;
    EX_br_taken     = s.br_taken;
    EX_br_target    = s.br_tgt;
    EX_pc           = s.pc;
    mem_busy        = s.mem_busy;
    model(s);
  endtask

  task automatic drive_n(input stim_t s, input int n);
    for (int i = 0; i < n; i++) drive(s);
  endtask

  // Monitor: every cycle with a pending expectation, compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      chk("pipe_hold",   64'(pipe_hold),   64'(e.hold));
      chk("stall_D",     64'(stall_D),     64'(e.stall_d));
      chk("stall_F",     64'(stall_F),     64'(e.stall_f));
      chk("EX_taken",    64'(EX_taken),    64'(e.taken));
      chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
      chk("mul_busy",    64'(mul_busy),    64'(e.busy));
      chk("perf_stall",  64'(perf_stall),  64'(e.ps));
      chk("perf_flush",  64'(perf_flush),  64'(e.pf));
      chk("perf_hold",   64'(perf_hold),   64'(e.ph));
    end
  end

  // Stimulus sequence and final report.
  initial begin
    stim_t s;
    stim_t idle;
    int waited;
    checks = 0;
    failures = 0;
    m_hold_left = 0;
    m_done_wait = 1'b0;
    m_ps = 0;
    m_pf = 0;
    m_ph = 0;
    rst = 1'b1;
    D_valid = 0; D_rs1 = 0; D_rs1_used = 0; D_rs2 = 0; D_rs2_used = 0;
    EX_rd = 0; EX_ld = 0; EX_mul = 0; EX_brn = 0; EX_BP_taken = 0;
    EX_BP_target_pc = 0; EX_br_taken = 0; EX_br_target = 0; EX_pc = 0;
    mem_busy = 0;

    idle = '0;
    idle.pc = 32'h40;
    s = idle; s.rst = 1'b1;
    drive_n(s, 2);
    drive(idle);

    // Load-use, then the load has moved on; then the x0 case.
    s = idle; s.d_valid = 1; s.ld = 1; s.ex_rd = 5; s.rs2 = 5; s.rs2_used = 1;
    drive(s);
    drive(idle);
    s.ex_rd = 0; s.rs2 = 0;
    drive(s);
    s = idle; s.d_valid = 1; s.ld = 1; s.ex_rd = 7; s.rs1 = 7; s.rs1_used = 1;
    drive(s);

    // Mispredicts: direction wrong both ways, target wrong, PC wrap.
    s = idle; s.brn = 1; s.bp_taken = 0; s.br_taken = 1; s.br_tgt = 32'h1000;
    drive(s);
    s = idle; s.brn = 1; s.bp_taken = 1; s.br_taken = 0; s.pc = 32'h200;
    drive(s);
    s = idle; s.brn = 1; s.bp_taken = 1; s.br_taken = 1; s.bp_tgt = 32'h300; s.br_tgt = 32'h304;
    drive(s);
    s.br_tgt = 32'h300;
    drive(s);
    s = idle; s.brn = 1; s.bp_taken = 1; s.br_taken = 0; s.pc = 32'hFFFF_FFFC;
    drive(s);

    // Deferred flush under a 3-cycle memory hold.
    s = idle; s.brn = 1; s.bp_taken = 0; s.br_taken = 1; s.br_tgt = 32'h2000; s.mem_busy = 1;
    drive_n(s, 3);
    s.mem_busy = 0;
    drive(s);
    drive(idle);

    // Two back-to-back multiplies, then one stretched by memory in DONE.
    s = idle; s.mul = 1;
    drive_n(s, 8);
    drive(idle);
    drive_n(s, 3);
    s.mem_busy = 1;
    drive_n(s, 2);
    s.mem_busy = 0;
    drive(s);
    drive(idle);

    // Flush beats bubble; hold beats bubble.
    s = idle; s.d_valid = 1; s.ld = 1; s.ex_rd = 3; s.rs1 = 3; s.rs1_used = 1;
    s.brn = 1; s.bp_taken = 0; s.br_taken = 1; s.br_tgt = 32'h3000;
    drive(s);
    s = idle; s.d_valid = 1; s.ld = 1; s.ex_rd = 3; s.rs1 = 3; s.rs1_used = 1; s.mul = 1;
    drive_n(s, 4);
    drive(idle);

    // Reset in the second BUSY cycle of a multiply.
    s = idle; s.mul = 1;
    drive_n(s, 2);
    s.rst = 1;
    drive(s);
    drive_n(idle, 2);

    // Random traffic with small register indices to provoke hazards;
    // PERF_W=8 lets the counters reach saturation.
    for (int i = 0; i < 3000; i++) begin
      s.rst      = ($urandom_range(0, 299) == 0);
      s.d_valid  = ($urandom_range(0, 3) != 0);
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs1_used = 1'($urandom_range(0, 1));
      s.rs2      = 5'($urandom_range(0, 3));
      s.rs2_used = 1'($urandom_range(0, 1));
      s.ex_rd    = 5'($urandom_range(0, 3));
      s.ld       = ($urandom_range(0, 2) == 0);
      s.mul      = ($urandom_range(0, 3) == 0);
      s.brn      = ($urandom_range(0, 2) == 0);
      s.bp_taken = 1'($urandom_range(0, 1));
      s.br_taken = 1'($urandom_range(0, 1));
      s.bp_tgt   = 32'h100 << $urandom_range(0, 1);
      s.br_tgt   = 32'h100 << $urandom_range(0, 1);
      s.pc       = $urandom;
      s.mem_busy = ($urandom_range(0, 4) == 0);
      drive(s);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline-control block that produces the control inputs consumed by the D->EX pipeline register and the other stage registers:
- load-use bubble insertion (stall_D / stall_F)
- global pipeline hold (pipe_hold, driven onto every stage register's MEM_stall input)
- branch-mispredict flush (EX_taken) with its redirect PC

It owns the multi-cycle multiply hold FSM and the stall/flush performance counters. It sits beside the decode and execute stages.

Parameters:
VPC_BITS, 32, virtual PC width
MUL_LAT, 4, multiplier latency in EX cycles (>=1; 1 = no hold)
PERF_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
D_valid  in  1  decode stage holds a real instruction
D_rs1  in  5  decode source register 1
D_rs1_used  in  1  rs1 actually read
D_rs2  in  5  decode source register 2
D_rs2_used  in  1  rs2 actually read
EX_rd  in  5  EX destination register
EX_ld  in  1  EX instruction is a load
EX_mul  in  1  EX instruction is a multiply
EX_brn  in  1  EX instruction is a branch/jump
EX_BP_taken  in  1  predicted direction carried to EX
EX_BP_target_pc  in  VPC_BITS  predicted target carried to EX
EX_br_taken  in  1  resolved direction
EX_br_target  in  VPC_BITS  resolved target
EX_pc  in  VPC_BITS  PC of EX instruction
mem_busy  in  1  data memory/cache not ready
pipe_hold  out  1  freeze all stage registers (to MEM_stall ports)
stall_D  out  1  insert bubble into EX
stall_F  out  1  hold PC and F->D register
EX_taken  out  1  flush younger stages and redirect fetch
redirect_pc  out  VPC_BITS  fetch target when EX_taken
mul_busy  out  1  multiply FSM not IDLE
perf_stall  out  PERF_W  load-use bubble count
perf_flush  out  PERF_W  flush count
perf_hold  out  PERF_W  pipe_hold cycle count

Behaviour:
Reset:
- While rst is high, all control outputs are forced 0; redirect_pc = 0.
- At the edge, the FSM goes to IDLE and all perf counters to 0.
- Reset mid-multiply aborts the count; pipe_hold is 0 in the rst cycle and afterwards.

Multiply FSM (IDLE, BUSY, DONE), 3-bit down-counter cnt:
- IDLE & EX_mul & MUL_LAT>1 -> BUSY, cnt = MUL_LAT-2. mul_hold is asserted combinationally in that IDLE cycle.
- BUSY: mul_hold = 1. cnt decrements each cycle, independent of mem_busy. At cnt==0 -> DONE.
- DONE: mul_hold = 0, so the multiply advances at the edge unless mem_busy. Stay in DONE while mem_busy; otherwise -> IDLE. This prevents re-triggering on the same instruction.
- A multiply immediately following in EX is detected again from IDLE.
- Total EX residency of a multiply with mem_busy low = MUL_LAT cycles.
- MUL_LAT == 1: FSM never leaves IDLE.

Hold:
- pipe_hold = mem_busy | mul_hold.

Mispredict:
- mispredict = EX_brn & ((EX_br_taken != EX_BP_taken) | (EX_br_taken & EX_BP_target_pc != EX_br_target)).
- EX_taken = mispredict & !pipe_hold. The flush is deferred while held, because flushing during a hold would destroy the unretired EX instruction. It fires in the first unheld cycle.
- redirect_pc = EX_br_taken ? EX_br_target : EX_pc + 4, modulo 2^VPC_BITS.

Load-use:
- hazard = D_valid & EX_ld & EX_rd != 0 & ((D_rs1_used & D_rs1 == EX_rd) | (D_rs2_used & D_rs2 == EX_rd)).
- stall_D = hazard & !pipe_hold & !EX_taken. stall_F = stall_D.
- A flush wins over a bubble; a hold wins over both.
- Exactly one bubble per load-use pair. The next cycle the load is in MEM and hazard drops.

Perf counters:
- Each increments by 1 in cycles where its signal (stall_D, EX_taken, pipe_hold) is 1.
- Counters saturate at all-ones; no wrap.

Latency:
- stall/flush/hold outputs are combinational from inputs and FSM state (same cycle).
- The FSM and counters update at the clock edge.

Decomposition:
- hazard_pkg: MUL FSM state encoding (IDLE=0, BUSY=1, DONE=2), REG_BITS=5, the PC increment constant 4, and a saturating-increment function.
- One sub-module, mul_hold_fsm (inputs clk, rst, EX_mul, mem_busy; outputs mul_hold, mul_busy). Everything else stays in the top level.

Test Plan:
1. Load-use: EX_ld=1, EX_rd=5, D_rs2=5, D_rs2_used=1, D_valid=1, mem_busy=0 -> stall_D=stall_F=1 for exactly 1 cycle; perf_stall=1. Repeat with EX_rd=0 -> no stall.
2. Mispredict: EX_brn=1, EX_BP_taken=0, EX_br_taken=1, EX_br_target=0x1000 -> EX_taken=1 and redirect_pc=0x1000 same cycle. Predicted taken but resolved not-taken at EX_pc=0x200 -> redirect_pc=0x204.
3. Deferred flush: mispredict with mem_busy=1 for 3 cycles -> EX_taken=0 for those 3 cycles, then 1 in cycle 4; perf_flush increments once.
4. Multiply, MUL_LAT=4: EX_mul held high -> pipe_hold=1 for 3 cycles, 0 in cycle 4; mul_busy 1 during BUSY/DONE. Back-to-back muls -> 3 hold cycles each.
5. Simultaneous load-use and mispredict -> EX_taken=1, stall_D=0. Load-use during mul hold -> stall_D=0 until hold releases.
6. Reset in the second BUSY cycle -> pipe_hold=0 in the rst cycle; FSM IDLE and perf counters 0 after the edge. Preload a perf counter near all-ones -> it saturates at 2^PERF_W-1.
